// File: rtl/alu_pkg.sv
// ============================================================================
//  Module  : alu_pkg
//  Brief   : Shared opcodes, FSM state encoding and default width for alu_seq.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;
  localparam logic [7:0] OP_AND = 8'h02;
  localparam logic [7:0] OP_OR  = 8'h03;
  localparam logic [7:0] OP_XOR = 8'h04;
  localparam logic [7:0] OP_NOT = 8'h05;
  localparam logic [7:0] OP_MUL = 8'h06;
  localparam logic [7:0] OP_DIV = 8'h07;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/alu_seq_iter_muldiv.sv
// ============================================================================
//  Module  : iter_muldiv
//  Brief   : One-bit-per-clock shift-add multiplier / restoring divider.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module iter_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc,
  output logic               last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic               active_q, active_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_shift;
  logic [2*WIDTH-1:0] step;

  // Divide keeps {remainder, quotient} in acc; the shifted partial remainder
  // needs one extra bit because it can reach 2*b-1.
  always_comb begin
    rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
    step      = acc_q;
    if (mode_q) begin
      step = {acc_q[2*WIDTH-2:0], 1'b0};
      if (rem_shift >= {1'b0, b_q}) begin
        step[2*WIDTH-1:WIDTH] = WIDTH'(rem_shift - {1'b0, b_q});
        step[0]               = 1'b1;
      end
    end else if (b_q[cnt_q]) begin
      step = acc_q + ({{WIDTH{1'b0}}, a_q} << cnt_q);
    end
  end

  always_comb begin
    active_d = active_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    if (load) begin
      active_d = 1'b1;
      mode_d   = mode;
      a_d      = a;
      b_d      = b;
      cnt_d    = '0;
      acc_d    = mode ? {{WIDTH{1'b0}}, a} : '0;
    end else if (active_q) begin
      acc_d = step;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      mode_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
    end else begin
      active_q <= active_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
    end
  end

  assign last = active_q && (cnt_q == CNT_LAST);
  // The caller captures the post-iteration value on the final edge.
  assign acc  = acc_d;

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
//  Module  : alu_seq
//  Brief   : Multi-cycle execution unit: single-cycle logic/add, iterative
//            multiply/divide, start/busy/done handshake.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [7:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               done,
  output logic               err
);

  logic [0:0]         state_q, state_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               load, last;
  logic [2*WIDTH-1:0] acc;
  logic               illegal, div_by_zero, is_iter;
  logic [WIDTH:0]     sum, diff;

  assign illegal     = (op > OP_DIV);
  assign div_by_zero = (op == OP_DIV) && (b == '0);
  assign is_iter     = ((op == OP_MUL) || (op == OP_DIV)) && !div_by_zero;
  assign sum         = {1'b0, a} + {1'b0, b};
  // Bit WIDTH of the 9-bit difference is exactly the borrow (a < b).
  assign diff        = {1'b0, a} - {1'b0, b};

  iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (load),
    .mode    (op == OP_DIV),
    .a       (a),
    .b       (b),
    .acc     (acc),
    .last    (last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && is_iter) state_d = ST_RUN;
      ST_RUN:  if (last)             state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    result_d = result_q;
    err_d    = err_q;
    done_d   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        if (illegal) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = 1'b1;
        end else if (div_by_zero) begin
          result_d = {a, {WIDTH{1'b1}}};
          err_d    = 1'b1;
          done_d   = 1'b1;
        end else if (is_iter) begin
          load = 1'b1;
        end else begin
          err_d  = 1'b0;
          done_d = 1'b1;
          case (op)
            OP_ADD:  result_d = {{(WIDTH-1){1'b0}}, sum};
            OP_SUB:  result_d = {{(WIDTH-1){1'b0}}, diff};
            OP_AND:  result_d = {{WIDTH{1'b0}}, a & b};
            OP_OR:   result_d = {{WIDTH{1'b0}}, a | b};
            OP_XOR:  result_d = {{WIDTH{1'b0}}, a ^ b};
            OP_NOT:  result_d = {{WIDTH{1'b0}}, ~a};
            default: result_d = '0;
          endcase
        end
      end
    end else if (last) begin
      result_d = acc;
      err_d    = 1'b0;
      done_d   = 1'b1;
    end
  end

  assign result = result_q;
  assign busy   = (state_q == ST_RUN);
  assign done   = done_q;
  assign err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
//  Module  : tb_alu_seq
//  Brief   : Directed plus randomized self-checking bench for alu_seq.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic         start   = 1'b0;
  logic [7:0]   op      = '0;
  logic [W-1:0] a       = '0;
  logic [W-1:0] b       = '0;
  logic [2*W-1:0] result;
  logic         busy, done, err;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .result  (result),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on unsigned operands.
  function automatic void model(input logic [7:0] o, input int unsigned x, input int unsigned y,
                                output int unsigned res, output bit e, output bit iter);
    e    = 1'b0;
    iter = 1'b0;
    res  = 0;
    case (o)
      OP_ADD: res = x + y;
      OP_SUB: res = (x + 512 - y) % 512;
      OP_AND: res = x & y;
      OP_OR:  res = x | y;
      OP_XOR: res = x ^ y;
      OP_NOT: res = 255 - x;
      OP_MUL: begin res = x * y; iter = 1'b1; end
      OP_DIV: begin
        if (y == 0) begin res = x * 256 + 255; e = 1'b1; end
        else begin res = (x % y) * 256 + x / y; iter = 1'b1; end
      end
      default: begin res = 0; e = 1'b1; end
    endcase
  endfunction

  task automatic issue(input logic [7:0] o, input logic [7:0] x, input logic [7:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock); #1;
    start = 1'b0;
    a  = 8'($urandom);
    b  = 8'($urandom);
    op = 8'($urandom);
  endtask

  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cnt++;
      @(posedge clock); #1;
      edges++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] o, input logic [7:0] x, input logic [7:0] y);
    int unsigned exp_res;
    bit exp_err, exp_iter;
    int edges, bcnt;
    model(o, x, y, exp_res, exp_err, exp_iter);
    issue(o, x, y);
    wait_done(edges, bcnt);
    check({tag, "_done"},    done, 1);
    check({tag, "_result"},  result, exp_res);
    check({tag, "_err"},     err, exp_err);
    check({tag, "_latency"}, edges, exp_iter ? W : 0);
    check({tag, "_busy"},    bcnt,  exp_iter ? W : 0);
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clock); #1;
    check({tag, "_pulse_end"}, done, 0);
  endtask

  initial begin
    int ed, bc, extra;
    logic [7:0] o, x, y;

    #12;
    check("rst_result", result, 0);
    check("rst_busy",   busy,   0);
    check("rst_done",   done,   0);
    check("rst_err",    err,    0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    run_op("add_carry", OP_ADD, 8'hFF, 8'h01);
    idle_cycle("add_carry");

    run_op("mul_ff", OP_MUL, 8'hFF, 8'hFF);
    run_op("sub_b2b", OP_SUB, 8'h03, 8'h05);
    idle_cycle("sub_b2b");

    run_op("div_c8_7", OP_DIV, 8'hC8, 8'h07);
    idle_cycle("div_c8_7");
    run_op("div_zero", OP_DIV, 8'h55, 8'h00);
    idle_cycle("div_zero");

    run_op("illegal", 8'h2A, 8'h11, 8'h22);
    idle_cycle("illegal");
    run_op("and_after_err", OP_AND, 8'hF0, 8'h3C);
    idle_cycle("and_after_err");

    // A second start during RUN must be ignored.
    issue(OP_MUL, 8'h12, 8'h34);
    repeat (2) begin @(posedge clock); #1; end
    start = 1'b1; op = OP_ADD; a = 8'hFF; b = 8'hFF;
    repeat (2) begin @(posedge clock); #1; end
    start = 1'b0;
    wait_done(ed, bc);
    check("mul_ign_done",   done,   1);
    check("mul_ign_result", result, 16'h03A8);
    check("mul_ign_err",    err,    0);
    extra = 0;
    repeat (4) begin
      @(posedge clock); #1;
      if (done) extra++;
    end
    check("mul_ign_extra_done", extra, 0);
    check("mul_ign_hold",       result, 16'h03A8);

    // Asynchronous reset in the middle of iteration 4.
    issue(OP_MUL, 8'hAB, 8'hCD);
    repeat (4) begin @(posedge clock); #1; end
    check("pre_rst_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_result", result, 0);
    check("mid_rst_busy",   busy,   0);
    check("mid_rst_done",   done,   0);
    check("mid_rst_err",    err,    0);
    @(negedge clock);
    reset_n = 1'b1;
    extra = 0;
    repeat (12) begin
      @(posedge clock); #1;
      if (done || busy) extra++;
    end
    check("post_rst_quiet", extra, 0);
    run_op("add_after_rst", OP_ADD, 8'h10, 8'h20);
    idle_cycle("add_after_rst");

    for (int i = 0; i < 60; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      o = (r < 8) ? 8'(r) : 8'($urandom_range(8, 255));
      x = 8'($urandom);
      y = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      run_op($sformatf("rnd%0d_op%0h", i, o), o, x, y);
      if ($urandom_range(0, 1) == 1) idle_cycle($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle 8-bit execution unit sitting directly downstream of the register file.
- Consumes operand bytes a and b plus the opcode byte (data[7:0] of the 24-bit instruction word). Produces the 16-bit result word that the register file writes back: high byte to reg_x, low byte to y.
- Single-cycle logic/add ops plus iterative shift-add multiply and restoring divide, with a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand width; result is 2*WIDTH bits; MUL/DIV iteration count equals WIDTH.

Ports:
- clock  input  1  system clock, rising-edge.
- reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- op  input  8  opcode byte; only codes 0x00-0x07 are legal.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- result  output  2*WIDTH  result word: {hi, lo}.
- busy  output  1  high while an iterative op is in progress.
- done  output  1  one-cycle pulse when result/err are updated.
- err  output  1  set with done for illegal op or divide-by-zero; held until next completion.

Behaviour:
- Reset (async, reset_n=0): result=0, busy=0, done=0, err=0, state=IDLE, iteration counter=0. Reset mid-MUL/DIV aborts; no done is produced for the aborted op.
- States: IDLE, RUN.
  - IDLE with start=1 and op in 0x00-0x05, illegal op, or DIV with b=0: result/err registered at that edge, done=1 for the following cycle, stay IDLE (latency 1).
  - IDLE with start=1 and op MUL/DIV with valid operands: latch a, b, op; clear accumulator; go to RUN; busy=1.
  - RUN: one iteration per edge, counter 0..WIDTH-1. On the edge where counter=WIDTH-1: write result, pulse done, drop busy, return to IDLE. MUL/DIV latency is WIDTH edges from the start-sample edge, i.e. 8 for the default.
- start while busy is ignored, with no queuing. start in the cycle done=1 is accepted, giving back-to-back ops.
- Inputs a, b, op may change after start is sampled; the internal copies are used.
- Opcodes and results, with a, b unsigned:
  - 0x00 ADD: {7'b0, carry, (a+b) mod 256}.
  - 0x01 SUB: {7'b0, borrow, (a-b) mod 256}; borrow=1 when a<b.
  - 0x02 AND: {8'h00, a&b}.
  - 0x03 OR: {8'h00, a|b}.
  - 0x04 XOR: {8'h00, a^b}.
  - 0x05 NOT: {8'h00, ~a}.
  - 0x06 MUL: full 16-bit product a*b.
  - 0x07 DIV: {remainder, quotient}.
  - DIV b=0: result={a, 8'hFF}, err=1, latency 1.
  - op>0x07: result=16'h0000, err=1, latency 1.
- err=0 for every legal completion.
- result holds its value between completions.
- done is never high for two consecutive cycles except for back-to-back single-cycle ops.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_ADD..OP_DIV.
  - state encoding IDLE/RUN.
  - WIDTH default.
- Sub-module iter_muldiv:
  - iterative shift-add multiplier and restoring divider sharing one 2*WIDTH accumulator and the counter.
  - interface: load, mode, a, b in; acc, last out.
- alu_seq holds the FSM, the single-cycle ops, and the output registers.

Test Plan:
- ADD a=0xFF b=0x01, start 1 cycle -> done next cycle, result=0x0100, err=0, busy never high.
- MUL a=0xFF b=0xFF -> busy high 8 cycles, done on 8th edge, result=0xFE01. Then SUB a=0x03 b=0x05 issued in the done cycle -> result=0x01FE on the next cycle.
- DIV a=0xC8 b=0x07 -> latency 8, result=0x041C (r=4, q=28), err=0. DIV a=0x55 b=0x00 -> latency 1, result=0x55FF, err=1.
- Illegal op=0x2A -> result=0x0000, err=1, done pulse. Following legal AND a=0xF0 b=0x3C -> result=0x0030, err=0.
- MUL a=0x12 b=0x34 with start re-asserted and a/b changed during RUN -> second start ignored, result=0x03A8, exactly one done.
- reset_n low at RUN iteration 4 -> outputs immediately 0, busy=0; no done after release. New ADD 0x10+0x20 -> result=0x0030.
